// File: rtl/rgb_frame_reader.sv
// Streams a packed RGB frame (3 SRAM words per 2 pixels) out of SRAM as 24-bit pixels
// on a valid/ready interface; credit-limited reads keep the word FIFO from overflowing.
module rgb_frame_reader #(
  parameter logic [17:0] BASE_ADDR    = 18'd146944,
  parameter int          FRAME_PIXELS = 76800,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        CLOCK_50_I,
  input  logic        Resetn,
  input  logic        start,
  output logic        done,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [7:0]  pix_R,
  output logic [7:0]  pix_G,
  output logic [7:0]  pix_B,
  output logic        pix_first
);

  localparam int WORDS  = FRAME_PIXELS * 3 / 2;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WCNT_W = $clog2(WORDS + 1);
  localparam int PCNT_W = $clog2(FRAME_PIXELS + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
  localparam logic [WCNT_W-1:0] LAST_WORD   = WCNT_W'(WORDS - 1);
  localparam logic [PCNT_W-1:0] LAST_PIXEL  = PCNT_W'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  logic [WCNT_W-1:0]   r_word_cnt;
  logic                r_vld_p1;
  logic                r_vld_p2;
  logic [15:0]         r_fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_fifo_cnt;
  logic [1:0]          r_phase;
  logic [PCNT_W-1:0]   r_pix_cnt;
  logic [7:0]          r_R0;
  logic [7:0]          r_G0;
  logic [7:0]          r_R1;

  logic [CNT_W-1:0]    w_inflight;
  logic                w_issue;
  logic                w_push;
  logic                w_pop;
  logic                w_emit;
  logic                w_accept;
  logic                w_out_free;
  logic                w_last_acc;
  logic [15:0]         w_fifo_q;
  logic [23:0]         w_emit_pix;

  assign SRAM_we_n  = 1'b1;
  assign w_inflight = CNT_W'(r_vld_p1) + CNT_W'(r_vld_p2);
  // Words already in the FIFO plus words still in the SRAM pipe must fit the FIFO.
  assign w_issue    = (r_state == S_FETCH) && ((r_fifo_cnt + w_inflight) < DEPTH_C);
  assign w_push     = r_vld_p2;
  assign w_fifo_q   = r_fifo_mem[r_rd_ptr];
  assign w_accept   = pix_valid && pix_ready;
  assign w_out_free = !pix_valid || pix_ready;
  assign w_pop      = (r_fifo_cnt != '0) && ((r_phase == 2'd0) || w_out_free);
  assign w_emit     = w_pop && (r_phase != 2'd0);
  assign w_last_acc = w_accept && (r_pix_cnt == LAST_PIXEL);

  always_comb begin
    w_emit_pix = {r_R1, w_fifo_q};
    if (r_phase == 2'd1) w_emit_pix = {r_R0, r_G0, w_fifo_q[15:8]};
  end

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      r_state      <= S_IDLE;
      SRAM_address <= BASE_ADDR;
      done         <= 1'b0;
      r_word_cnt   <= '0;
      r_vld_p1     <= 1'b0;
      r_vld_p2     <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_cnt   <= '0;
      r_phase      <= 2'd0;
      r_pix_cnt    <= '0;
      pix_valid    <= 1'b0;
      pix_first    <= 1'b0;
      pix_R        <= 8'd0;
      pix_G        <= 8'd0;
      pix_B        <= 8'd0;
    end else begin
      done <= 1'b0;

      // p0 -> p1 -> p2: read issued, SRAM latency, data lands in FIFO
      r_vld_p1 <= w_issue;
      r_vld_p2 <= r_vld_p1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_fifo_cnt <= r_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_pop);

      // unpack -> output register
      if (w_pop) r_phase <= (r_phase == 2'd2) ? 2'd0 : 2'(r_phase + 2'd1);
      if (w_emit) begin
        pix_valid <= 1'b1;
        pix_first <= !pix_valid && (r_pix_cnt == '0);
        {pix_R, pix_G, pix_B} <= w_emit_pix;
      end else if (w_accept) begin
        pix_valid <= 1'b0;
        pix_first <= 1'b0;
      end
      if (w_accept) r_pix_cnt <= r_pix_cnt + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_FETCH;
            r_word_cnt <= '0;
          end
        end
        S_FETCH: begin
          if (w_issue) begin
            SRAM_address <= BASE_ADDR + 18'(r_word_cnt);
            r_word_cnt   <= r_word_cnt + 1'b1;
            if (r_word_cnt == LAST_WORD) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_last_acc) begin
            r_state <= S_DONE;
            done    <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_pix_cnt  <= '0;
          r_word_cnt <= '0;
        end
      endcase
    end
  end

  // Datapath storage carries no reset; control above qualifies every use.
  always_ff @(posedge CLOCK_50_I) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= SRAM_read_data;
    if (w_pop) begin
      if (r_phase == 2'd0) {r_R0, r_G0} <= w_fifo_q;
      else if (r_phase == 2'd1) r_R1 <= w_fifo_q[7:0];
    end
  end

endmodule

// File: tb/tb_rgb_frame_reader.sv
// Scoreboard bench for rgb_frame_reader: frames are queued at start, a negedge monitor
// compares every accepted pixel, plus stall, random-ready, mid-frame start and reset cases.
module tb_rgb_frame_reader;

  localparam logic [17:0] BASE  = 18'd261844;
  localparam int          FRAME = 200;
  localparam int          WORDS = FRAME * 3 / 2;
  localparam logic [17:0] LAST  = 18'd262143;

  logic        clk;
  logic        Resetn;
  logic        start;
  logic        done;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_R;
  logic [7:0]  pix_G;
  logic [7:0]  pix_B;
  logic        pix_first;

  int          n_err = 0;
  int          n_checks = 0;
  int          n_acc = 0;
  int          n_done = 0;
  int          mode = 0;
  bit          exp_done_next = 0;
  bit          held_vld = 0;
  logic [24:0] held;
  bit          prev_done = 0;
  bit          we_bad = 0;
  bit          addr_bad = 0;
  logic [24:0] exp_q[$];

  rgb_frame_reader #(
    .BASE_ADDR(BASE), .FRAME_PIXELS(FRAME), .FIFO_DEPTH(8)
  ) dut (
    .CLOCK_50_I(clk), .Resetn(Resetn), .start(start), .done(done),
    .SRAM_address(SRAM_address), .SRAM_we_n(SRAM_we_n), .SRAM_read_data(SRAM_read_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_R(pix_R), .pix_G(pix_G), .pix_B(pix_B), .pix_first(pix_first)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [17:0] a);
    logic [17:0] o;
    logic [31:0] h;
    logic [15:0] r;
    o = a - BASE;
    h = {14'b0, o} * 32'h9E37 + 32'h1234;
    r = h[15:0] ^ h[31:16];
    if (o == 18'd0) r = 16'hA1B2;
    if (o == 18'd1) r = 16'hC3D4;
    if (o == 18'd2) r = 16'hE5F6;
    return r;
  endfunction

  function automatic logic [23:0] pix_model(input int p);
    logic [15:0] w0, w1, w2;
    logic [17:0] a;
    a  = BASE + 18'(3 * (p / 2));
    w0 = mem_word(a);
    w1 = mem_word(a + 18'd1);
    w2 = mem_word(a + 18'd2);
    return (p % 2 == 0) ? {w0, w1[15:8]} : {w1[7:0], w2};
  endfunction

  // SRAM: data for the address presented in one cycle appears in the next.
  always @(posedge clk) SRAM_read_data <= mem_word(SRAM_address);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!Resetn) begin
      exp_q.delete();
      n_acc = 0;
      exp_done_next = 0;
      held_vld = 0;
      prev_done = 0;
    end else begin
      if (SRAM_we_n !== 1'b1) we_bad = 1;
      if (SRAM_address < BASE) addr_bad = 1;
      if (exp_done_next) begin
        chk("done_after_last_pixel", 32'(done), 32'd1);
        exp_done_next = 0;
        n_acc = 0;
      end
      if (done) begin
        n_done++;
        chk("done_single_cycle", 32'(prev_done), 32'd0);
      end
      prev_done = done;
      if (held_vld) chk("pixel_held_stable", 32'({pix_valid, pix_first, pix_R, pix_G, pix_B}),
                        32'({1'b1, held}));
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pixel", 32'(n_acc), 32'hFFFF_FFFF);
        end else begin
          chk($sformatf("pixel_%0d", n_acc), 32'({pix_first, pix_R, pix_G, pix_B}),
              32'(exp_q.pop_front()));
        end
        n_acc++;
        if (n_acc == FRAME) exp_done_next = 1;
      end
      held_vld = pix_valid && !pix_ready;
      held = {pix_first, pix_R, pix_G, pix_B};
    end
  end

  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: pix_ready = 1'b1;
        1: pix_ready = 1'b0;
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic launch();
    for (int p = 0; p < FRAME; p++) begin
      logic [23:0] rgb;
      rgb = (p == 0) ? 24'hA1B2C3 : (p == 1) ? 24'hD4E5F6 : pix_model(p);
      exp_q.push_back({(p == 0), rgb});
    end
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    chk("first_address", 32'(SRAM_address), 32'(BASE));
    repeat (3) @(negedge clk);
    chk("no_pixel_before_latency", 32'(pix_valid), 32'd0);
  endtask

  task automatic wait_acc(input int n);
    for (int i = 0; i < 5000 && n_acc < n; i++) @(negedge clk);
    chk("wait_pixels_timeout", 32'(n_acc >= n), 32'd1);
  endtask

  task automatic wait_done();
    int d0;
    d0 = n_done;
    for (int i = 0; i < 5000 && n_done == d0; i++) @(negedge clk);
    chk("wait_done_timeout", 32'(n_done > d0), 32'd1);
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int d0, a, c, issued;
    logic [17:0] addr_snap;
    Resetn = 1'b0;
    start  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_address", 32'(SRAM_address), 32'(BASE));
    chk("rst_we_n", 32'(SRAM_we_n), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_pix_rgb", 32'({pix_R, pix_G, pix_B}), 32'd0);
    chk("rst_pix_first", 32'(pix_first), 32'd0);
    @(negedge clk) Resetn = 1'b1;

    // Full frame, always ready
    mode = 0;
    launch();
    wait_done();
    chk("last_address", 32'(SRAM_address), 32'(LAST));
    repeat (5) @(negedge clk);
    chk("address_no_wrap", 32'(SRAM_address), 32'(LAST));
    chk("idle_pix_valid", 32'(pix_valid), 32'd0);

    // Consumer stalls for 50 cycles mid-frame
    launch();
    wait_acc(20);
    mode = 1;
    repeat (40) @(negedge clk);
    addr_snap = SRAM_address;
    repeat (10) @(negedge clk);
    chk("stall_reads_stopped", 32'(SRAM_address), 32'(addr_snap));
    chk("stall_pix_valid", 32'(pix_valid), 32'd1);
    a = n_acc;
    c = (a % 2 == 0) ? 3 * (a / 2) + 2 : 3 * ((a - 1) / 2) + 4;
    issued = int'(SRAM_address - BASE) + 1;
    chk("stall_words_outstanding", 32'(issued), 32'(c + 8));
    mode = 0;
    wait_done();

    // Random ready
    mode = 2;
    launch();
    wait_done();
    mode = 0;

    // Start pulse mid-frame is ignored
    d0 = n_done;
    launch();
    wait_acc(50);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done();
    repeat (10) @(negedge clk);
    chk("single_done_per_frame", 32'(n_done - d0), 32'd1);

    // Reset mid-frame, then restart
    launch();
    wait_acc(100);
    @(negedge clk);
    #2 Resetn = 1'b0;
    #1;
    chk("midrst_pix_valid", 32'(pix_valid), 32'd0);
    chk("midrst_address", 32'(SRAM_address), 32'(BASE));
    chk("midrst_done", 32'(done), 32'd0);
    d0 = n_done;
    repeat (2) @(negedge clk);
    #2 Resetn = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_no_done", 32'(n_done), 32'(d0));
    launch();
    wait_done();

    chk("we_n_always_high", 32'(we_bad), 32'd0);
    chk("address_in_range", 32'(addr_bad), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1);
  end

endmodule
